// File: rtl/rp_8bit_pkg.sv
// Shared types and constants for the rp8 multiply sequencer and its datapath.
package rp_8bit_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULS   = 3'd1,
    MULSU  = 3'd2,
    FMUL   = 3'd3,
    FMULS  = 3'd4,
    FMULSU = 3'd5
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_WBL  = 2'd2,
    ST_WBH  = 2'd3
  } mul_state_t;

  localparam int         MUL_STEPS  = 8;
  localparam logic [4:0] MUL_RES_LO = 5'd0;
  localparam logic [4:0] MUL_RES_HI = 5'd1;

  // Encodings outside the defined set behave as a plain unsigned mul.
  function automatic mul_op_t op_norm(input logic [2:0] raw);
    return (raw > 3'd5) ? MUL : mul_op_t'(raw);
  endfunction

  function automatic logic op_m_signed(input mul_op_t op);
    return op inside {MULS, MULSU, FMULS, FMULSU};
  endfunction

  function automatic logic op_rr_signed(input mul_op_t op);
    return op inside {MULS, FMULS};
  endfunction

  function automatic logic op_frac(input mul_op_t op);
    return op inside {FMUL, FMULS, FMULSU};
  endfunction

endpackage

// File: rtl/rp_8bit_mul_dp.sv
// Radix-2 shift-add datapath: one partial-product step per i_step, result and C/Z
// formed combinationally from the accumulator; no flow control of its own.
module rp_8bit_mul_dp
  import rp_8bit_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = $clog2(DW)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [CW-1:0]   i_cnt,
  input  logic [2:0]      i_op,
  input  logic [DW-1:0]   i_rd,
  input  logic [DW-1:0]   i_rr,
  output logic [2*DW-1:0] o_res,
  output logic            o_c,
  output logic            o_z
);

  mul_op_t         w_op;
  logic [DW:0]     r_m;
  logic [DW-1:0]   r_rr;
  logic            r_rr_sgn;
  logic            r_frac;
  logic [2*DW:0]   r_acc;

  logic            w_add;
  logic            w_sub;
  logic [DW+1:0]   w_up;
  logic [DW+1:0]   w_mx;
  logic [DW+1:0]   w_sum;
  logic [2*DW:0]   w_acc_nxt;
  logic [2*DW-1:0] w_p;

  assign w_op = op_norm(i_op);

  // The add is done one bit wider than the 9-bit upper accumulator so the
  // bit shifted back in is the true sign, even when an unsigned sum exceeds 255.
  always_comb begin
    w_add     = r_rr[i_cnt];
    w_sub     = w_add && r_rr_sgn && (i_cnt == CW'(DW - 1));
    w_up      = {r_acc[2*DW], r_acc[2*DW:DW]};
    w_mx      = {r_m[DW], r_m};
    w_sum     = w_up;
    if (w_sub) begin
      w_sum = w_up - w_mx;
    end else if (w_add) begin
      w_sum = w_up + w_mx;
    end
    w_acc_nxt = {w_sum, r_acc[DW-1:1]};
    w_p       = r_acc[2*DW-1:0];
    o_res     = r_frac ? {w_p[2*DW-2:0], 1'b0} : w_p;
    o_c       = w_p[2*DW-1];
    o_z       = (o_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m      <= '0;
      r_rr     <= '0;
      r_rr_sgn <= 1'b0;
      r_frac   <= 1'b0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_m      <= op_m_signed(w_op) ? {i_rd[DW-1], i_rd} : {1'b0, i_rd};
      r_rr     <= i_rr;
      r_rr_sgn <= op_rr_signed(w_op);
      r_frac   <= op_frac(w_op);
      r_acc    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/rp_8bit_mul_seq.sv
// Multiply sequencer: accept -> 8 CALC cycles -> r0 then r1 byte writes; 11 cycles min.
// Issue stalls (req_rdy=0) while busy; each write byte holds until wb_rdy grants it.
module rp_8bit_mul_seq
  import rp_8bit_pkg::*;
#(
  parameter int RF_AW = 5,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [2:0]       req_op,
  input  logic [DW-1:0]    req_rd,
  input  logic [DW-1:0]    req_rr,
  input  logic             abort,
  output logic             busy,
  output logic             wb_vld,
  input  logic             wb_rdy,
  output logic [RF_AW-1:0] wb_adr,
  output logic [DW-1:0]    wb_dat,
  output logic             flg_vld,
  output logic             flg_c,
  output logic             flg_z
);

  localparam logic [2:0] LAST_STEP = 3'(MUL_STEPS - 1);

  mul_state_t      r_state;
  mul_state_t      w_state_nxt;
  logic [2:0]      r_cnt;
  logic            r_flg_c;
  logic            r_flg_z;
  logic            w_accept;
  logic            w_step;
  logic [2*DW-1:0] w_res;
  logic            w_c;
  logic            w_z;

  assign w_accept = (r_state == ST_IDLE) && req_vld && !abort;
  assign w_step   = (r_state == ST_CALC);

  rp_8bit_mul_dp #(
    .DW (DW),
    .CW (3)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_step (w_step),
    .i_cnt  (r_cnt),
    .i_op   (req_op),
    .i_rd   (req_rd),
    .i_rr   (req_rr),
    .o_res  (w_res),
    .o_c    (w_c),
    .o_z    (w_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort only cancels during CALC; once write-back begins the product commits.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
      ST_CALC: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == LAST_STEP) begin
          w_state_nxt = ST_WBL;
        end
      end
      ST_WBL:  if (wb_rdy) w_state_nxt = ST_WBH;
      ST_WBH:  if (wb_rdy) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_rdy = (r_state == ST_IDLE);
    busy    = (r_state != ST_IDLE);
    wb_vld  = (r_state == ST_WBL) || (r_state == ST_WBH);
    wb_adr  = '0;
    wb_dat  = '0;
    if (r_state == ST_WBL) begin
      wb_adr = RF_AW'(MUL_RES_LO);
      wb_dat = w_res[DW-1:0];
    end else if (r_state == ST_WBH) begin
      wb_adr = RF_AW'(MUL_RES_HI);
      wb_dat = w_res[2*DW-1:DW];
    end
    flg_vld = (r_state == ST_WBH) && wb_rdy;
    flg_c   = flg_vld ? w_c : r_flg_c;
    flg_z   = flg_vld ? w_z : r_flg_z;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flg_c <= 1'b0;
      r_flg_z <= 1'b0;
    end else if (flg_vld) begin
      r_flg_c <= w_c;
      r_flg_z <= w_z;
    end
  end

endmodule

// File: tb/tb_rp_8bit_mul_seq.sv
// Self-checking bench for rp_8bit_mul_seq: scoreboard of expected writes/flags from a
// native-multiply reference model, plus per-scenario timing and protocol checks.
module tb_rp_8bit_mul_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_vld = 1'b0;
  logic       req_rdy;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_rd = 8'h00;
  logic [7:0] req_rr = 8'h00;
  logic       abort = 1'b0;
  logic       busy;
  logic       wb_vld;
  logic       wb_rdy = 1'b1;
  logic [4:0] wb_adr;
  logic [7:0] wb_dat;
  logic       flg_vld;
  logic       flg_c;
  logic       flg_z;

  int errors  = 0;
  int checks  = 0;
  int flg_cnt = 0;

  logic [12:0] wb_q[$];
  logic [1:0]  flg_q[$];

  // {op, rd, rr}
  localparam logic [18:0] VEC [10] = '{
    {3'd1, 8'h80, 8'h80},
    {3'd2, 8'hFF, 8'hFF},
    {3'd4, 8'h80, 8'h80},
    {3'd3, 8'hC0, 8'h80},
    {3'd0, 8'h00, 8'h5A},
    {3'd2, 8'h80, 8'h02},
    {3'd5, 8'h80, 8'hFF},
    {3'd1, 8'h7F, 8'h80},
    {3'd6, 8'h12, 8'h34},
    {3'd7, 8'hFF, 8'h02}
  };

  always #5 clk = ~clk;

  rp_8bit_mul_seq #(.RF_AW(5), .DW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req_op  (req_op),
    .req_rd  (req_rd),
    .req_rr  (req_rr),
    .abort   (abort),
    .busy    (busy),
    .wb_vld  (wb_vld),
    .wb_rdy  (wb_rdy),
    .wb_adr  (wb_adr),
    .wb_dat  (wb_dat),
    .flg_vld (flg_vld),
    .flg_c   (flg_c),
    .flg_z   (flg_z)
  );

  // Returns {C, Z, R[15:0]}
  function automatic logic [17:0] model(input logic [2:0] op, input logic [7:0] rd, input logic [7:0] rr);
    int          a;
    int          b;
    int          p;
    logic [15:0] pl;
    logic [15:0] r;
    a  = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5) ? int'($signed(rd)) : int'(rd);
    b  = (op == 3'd1 || op == 3'd4) ? int'($signed(rr)) : int'(rr);
    p  = a * b;
    pl = p[15:0];
    r  = (op == 3'd3 || op == 3'd4 || op == 3'd5) ? {pl[14:0], 1'b0} : pl;
    return {pl[15], (r == 16'h0000), r};
  endfunction

  always @(negedge clk) begin
    logic [12:0] ew;
    logic [1:0]  ef;
    if (rst_n && wb_vld && wb_rdy) begin
      checks++;
      if (wb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got adr=%0d dat=%h, required no write", wb_adr, wb_dat);
      end else begin
        ew = wb_q.pop_front();
        if ({wb_adr, wb_dat} !== ew) begin
          errors++;
          $display("FAIL wb_write: got adr=%0d dat=%h, required adr=%0d dat=%h", wb_adr, wb_dat, ew[12:8], ew[7:0]);
        end
      end
    end
    if (rst_n && flg_vld) begin
      flg_cnt++;
      checks++;
      if (flg_q.size() == 0) begin
        errors++;
        $display("FAIL flg_unexpected: got c=%b z=%b, required no strobe", flg_c, flg_z);
      end else begin
        ef = flg_q.pop_front();
        if ({flg_c, flg_z} !== ef) begin
          errors++;
          $display("FAIL flags: got c=%b z=%b, required c=%b z=%b", flg_c, flg_z, ef[1], ef[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!req_rdy && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (!req_rdy) begin
      errors++;
      $display("FAIL %s_idle_timeout: req_rdy=%b after %0d cycles, required 1", name, req_rdy, n);
    end
  endtask

  // Drives one request in the current cycle; returns one cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [7:0] rd, input logic [7:0] rr, input bit exp);
    logic [17:0] m;
    wait_idle("issue");
    if (exp) begin
      m = model(op, rd, rr);
      wb_q.push_back({5'd0, m[7:0]});
      wb_q.push_back({5'd1, m[15:8]});
      flg_q.push_back(m[17:16]);
    end
    req_vld = 1'b1;
    req_op  = op;
    req_rd  = rd;
    req_rr  = rr;
    step();
    req_vld = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({req_rdy, busy, wb_vld, wb_adr, wb_dat, flg_vld, flg_c, flg_z} !== {1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: got rdy=%b busy=%b wb_vld=%b adr=%0d dat=%h flg_vld=%b c=%b z=%b, required 1 0 0 0 00 0 0 0",
               name, req_rdy, busy, wb_vld, wb_adr, wb_dat, flg_vld, flg_c, flg_z);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    wb_rdy = 1'b1;
    issue(3'd0, 8'hFF, 8'hFF, 1'b1);
    checks++;
    if ({busy, req_rdy} !== 2'b10) begin
      errors++;
      $display("FAIL lat_busy_t1: got busy=%b rdy=%b, required busy=1 rdy=0", busy, req_rdy);
    end
    repeat (7) step();
    checks++;
    if (wb_vld !== 1'b0) begin
      errors++;
      $display("FAIL lat_t8_no_wb: got wb_vld=%b, required 0", wb_vld);
    end
    step();
    checks++;
    if ({wb_vld, wb_adr, wb_dat} !== {1'b1, 5'd0, 8'h01}) begin
      errors++;
      $display("FAIL lat_t9_wbl: got vld=%b adr=%0d dat=%h, required 1 0 01", wb_vld, wb_adr, wb_dat);
    end
    step();
    checks++;
    if ({wb_vld, wb_adr, wb_dat, flg_vld, flg_c, flg_z} !== {1'b1, 5'd1, 8'hFE, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lat_t10_wbh: got vld=%b adr=%0d dat=%h fv=%b c=%b z=%b, required 1 1 fe 1 1 0",
               wb_vld, wb_adr, wb_dat, flg_vld, flg_c, flg_z);
    end
    step();
    checks++;
    if ({req_rdy, busy, flg_vld, flg_c, flg_z} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lat_t11_idle: got rdy=%b busy=%b fv=%b c=%b z=%b, required 1 0 0 1 0",
               req_rdy, busy, flg_vld, flg_c, flg_z);
    end
  endtask

  task automatic test_ops();
    wb_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(VEC[i][18:16], VEC[i][15:8], VEC[i][7:0], 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1);
    end
    wait_idle("ops");
  endtask

  task automatic test_stall();
    int          n = 0;
    int          f0;
    logic [17:0] m;
    f0 = flg_cnt;
    m  = model(3'd1, 8'h7F, 8'h81);
    wb_rdy = 1'b0;
    issue(3'd1, 8'h7F, 8'h81, 1'b1);
    while (!wb_vld && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!wb_vld) begin
      errors++;
      $display("FAIL stall_reach_wbl: got wb_vld=%b, required 1", wb_vld);
    end
    repeat (2) begin
      step();
      checks++;
      if ({wb_vld, wb_adr, wb_dat, flg_vld} !== {1'b1, 5'd0, m[7:0], 1'b0}) begin
        errors++;
        $display("FAIL stall_wbl_hold: got vld=%b adr=%0d dat=%h fv=%b, required 1 0 %h 0",
                 wb_vld, wb_adr, wb_dat, flg_vld, m[7:0]);
      end
    end
    wb_rdy = 1'b1;
    step();
    wb_rdy = 1'b0;
    abort  = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if ({wb_vld, wb_adr, wb_dat, flg_vld} !== {1'b1, 5'd1, m[15:8], 1'b0}) begin
        errors++;
        $display("FAIL stall_wbh_hold: got vld=%b adr=%0d dat=%h fv=%b, required 1 1 %h 0",
                 wb_vld, wb_adr, wb_dat, flg_vld, m[15:8]);
      end
    end
    wb_rdy = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (req_rdy !== 1'b1 || (flg_cnt - f0) != 1) begin
      errors++;
      $display("FAIL stall_done: got rdy=%b strobes=%0d, required rdy=1 strobes=1", req_rdy, flg_cnt - f0);
    end
  endtask

  task automatic test_abort();
    int f0;
    int seen = 0;
    f0 = flg_cnt;
    wb_rdy = 1'b1;
    issue(3'd0, 8'hFF, 8'hFF, 1'b0);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({req_rdy, busy} !== 2'b10) begin
      errors++;
      $display("FAIL abort_calc: got rdy=%b busy=%b, required rdy=1 busy=0", req_rdy, busy);
    end
    repeat (12) begin
      step();
      if (wb_vld) seen++;
    end
    checks++;
    if (seen != 0 || flg_cnt != f0) begin
      errors++;
      $display("FAIL abort_no_commit: got wb cycles=%0d strobes=%0d, required 0 0", seen, flg_cnt - f0);
    end
    req_vld = 1'b1;
    abort   = 1'b1;
    req_op  = 3'd0;
    req_rd  = 8'h03;
    req_rr  = 8'h03;
    step();
    req_vld = 1'b0;
    abort   = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_async_reset();
    issue(3'd0, 8'hFF, 8'hFF, 1'b0);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    wb_rdy = 1'b1;
    issue(3'd4, 8'h40, 8'hC0, 1'b1);
    issue(3'd2, 8'h81, 8'h7F, 1'b1);
    issue(3'd0, 8'h01, 8'h00, 1'b1);
    wait_idle("b2b");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_stall();
    test_abort();
    test_async_reset();
    test_back_to_back();
    repeat (2) step();
    checks++;
    if (wb_q.size() != 0 || flg_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d writes %0d flags pending, required 0 0", wb_q.size(), flg_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
